// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide,
// one step per cycle, with sign fix-up, divide-by-zero/overflow bypass and hold/flush control.
`timescale 1ns/1ps
module mdu_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            stallreq_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [2:0]        op_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [XLEN-1:0]   opnd_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic              neg_res_reg;
  logic              special_reg;
  logic [XLEN-1:0]   result_reg;

  // Operand decode for the accepting cycle
  logic            is_div_in;
  logic            a_sgn_in;
  logic            b_sgn_in;
  logic            a_neg_in;
  logic            b_neg_in;
  logic [XLEN-1:0] a_abs_in;
  logic [XLEN-1:0] b_abs_in;
  logic            div_zero_in;
  logic            ovf_in;
  logic            special_in;
  logic [XLEN-1:0] special_val_in;
  logic            res_neg_in;

  always_comb begin
    is_div_in   = op_i[2];
    a_sgn_in    = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                  (op_i == OP_DIV)  || (op_i == OP_REM);
    b_sgn_in    = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    a_neg_in    = a_sgn_in & a_i[XLEN-1];
    b_neg_in    = b_sgn_in & b_i[XLEN-1];
    a_abs_in    = a_neg_in ? -a_i : a_i;
    b_abs_in    = b_neg_in ? -b_i : b_i;
    div_zero_in = is_div_in & (b_i == '0);
    ovf_in      = is_div_in & ~op_i[0] & (a_i == MIN_VAL) & (b_i == '1);
    special_in  = div_zero_in | ovf_in;
    if (div_zero_in) begin
      special_val_in = op_i[1] ? a_i : '1;
    end else begin
      special_val_in = op_i[1] ? '0 : a_i;
    end
    // Remainder takes the dividend's sign; product and quotient take the XOR.
    res_neg_in = (is_div_in & op_i[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
  end

  // One multiply step: conditional add into the high half, then shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  // One restoring divide step: shift left, trial subtract, keep if non-negative.
  logic [XLEN:0]     div_sh;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_step;

  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_step = {mul_sum, acc_reg[XLEN-1:1]};
    div_sh   = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd_reg};
    div_ge   = ~div_diff[XLEN];
    div_step = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                acc_reg[XLEN-2:0], div_ge};
  end

  // Sign correction: the product is negated as a whole before picking a half.
  logic [2*XLEN-1:0] mul_full;
  logic [XLEN-1:0]   div_sel;
  logic [XLEN-1:0]   fix_val;

  always_comb begin
    mul_full = neg_res_reg ? -acc_reg : acc_reg;
    div_sel  = op_reg[1] ? acc_reg[2*XLEN-1:XLEN] : acc_reg[XLEN-1:0];
    if (op_reg[2]) begin
      fix_val = neg_res_reg ? -div_sel : div_sel;
    end else if (op_reg == OP_MUL) begin
      fix_val = mul_full[XLEN-1:0];
    end else begin
      fix_val = mul_full[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush_i) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: if (start_i) state_next = special_in ? S_FIX : S_CALC;
        S_CALC: if (cnt_reg == CNT_W'(1)) state_next = S_FIX;
        S_FIX:  state_next = S_DONE;
        S_DONE: if (!hold_i) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_reg      <= '0;
      cnt_reg     <= '0;
      opnd_reg    <= '0;
      acc_reg     <= '0;
      neg_res_reg <= 1'b0;
      special_reg <= 1'b0;
      result_reg  <= '0;
    end else if (flush_i) begin
      cnt_reg     <= '0;
      special_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            op_reg      <= op_i;
            neg_res_reg <= res_neg_in;
            special_reg <= special_in;
            // Multiply keeps |b| in the low half and adds |a|; divide shifts |a| out against |b|.
            acc_reg     <= {{XLEN{1'b0}}, (is_div_in ? a_abs_in : b_abs_in)};
            opnd_reg    <= is_div_in ? b_abs_in : a_abs_in;
            cnt_reg     <= special_in ? '0 : CNT_W'(XLEN);
            if (special_in) begin
              result_reg <= special_val_in;
            end
          end
        end
        S_CALC: begin
          acc_reg <= op_reg[2] ? div_step : mul_step;
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
        S_FIX: begin
          if (!special_reg) begin
            result_reg <= fix_val;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o     = (state_reg == S_CALC) || (state_reg == S_FIX);
    stallreq_o = rst_n & (((state_reg == S_IDLE) & start_i & ~flush_i) | busy_o);
    done_o     = (state_reg == S_DONE);
    result_o   = (state_reg == S_DONE) ? result_reg : '0;
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter (XLEN=32): arithmetic reference plus latency-level timing model,
// checked every cycle, with directed vectors carrying hand-computed results.
`timescale 1ns/1ps
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        hold_i = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic        busy_o;
  logic        stallreq_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic        started = 1'b0;
  logic        m_pend = 1'b0;
  logic        m_done = 1'b0;
  int          m_due = 0;
  logic [31:0] m_res = 32'd0;

  mdu_iter #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .hold_i     (hold_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .busy_o     (busy_o),
    .stallreq_o (stallreq_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    longint ub;
    logic [63:0] p;
    int qa;
    int qb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    qa = $signed(a);
    qb = $signed(b);
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return 32'(qa / qb);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return 32'(qa % qb);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Cycles from acceptance to first done: bypassed divides take 2, everything else XLEN+2.
  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 32'd0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Timing model: an accepted op is in flight until its due cycle, then shows done until hold drops.
  always @(posedge clk) begin
    started <= 1'b1;
    cyc     <= cyc + 1;
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_done <= 1'b0;
    end else if (flush_i) begin
      m_pend <= 1'b0;
      m_done <= 1'b0;
    end else if (m_done) begin
      m_done <= hold_i;
    end else if (m_pend) begin
      if (cyc + 1 == m_due) begin
        m_pend <= 1'b0;
        m_done <= 1'b1;
      end
    end else if (start_i) begin
      m_pend <= 1'b1;
      m_due  <= cyc + lat_of(op_i, a_i, b_i);
      m_res  <= ref_res(op_i, a_i, b_i);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("done", 64'(done_o), 64'(m_done));
      chk("result", 64'(result_o), 64'(m_done ? m_res : 32'd0));
      chk("busy", 64'(busy_o), 64'(m_pend));
      chk("stallreq", 64'(stallreq_o),
          64'(rst_n && (m_pend || (!m_done && start_i && !flush_i))));
    end
  end

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int n;
    int k;
    bit seen;
    k = 0;
    while ((m_pend || m_done) && k < 100) begin
      @(posedge clk); #2;
      k++;
    end
    if (m_pend || m_done) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_wait actual=busy required=idle", name);
    end
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    n       = cyc;
    @(posedge clk); #2;
    start_i = 1'b0;
    a_i     = $urandom;
    b_i     = $urandom;
    seen    = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    if (seen) begin
      chk({name, "_res"}, 64'(result_o), 64'(exp));
      chk({name, "_lat"}, 64'(cyc - n), 64'(exp_lat));
      $display("op %s op=%0d a=%h b=%h result=%h latency=%0d", name, op, a, b, result_o, cyc - n);
    end else begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done_within_60", name);
    end
    @(posedge clk); #2;
  endtask

  initial begin
    int n;
    // Model pins against hand-computed values
    chk("model_mulhu", 64'(ref_res(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF)), 64'h00000000FFFFFFFE);
    chk("model_div", 64'(ref_res(3'd4, 32'hFFFFFFF9, 32'd2)), 64'h00000000FFFFFFFD);
    chk("model_rem", 64'(ref_res(3'd6, 32'hFFFFFFF9, 32'd2)), 64'h00000000FFFFFFFF);
    chk("model_mulhsu", 64'(ref_res(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF)), 64'h00000000FFFFFFFF);

    repeat (2) @(posedge clk);
    start_i = 1'b1;
    @(negedge clk);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_stall", 64'(stallreq_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    @(posedge clk); #2;
    start_i = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk); #2;

    do_op("mulhu_ones", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    do_op("mul_ones", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34);
    do_op("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    do_op("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    do_op("divu_by0", 3'd5, 32'h00001234, 32'd0, 32'hFFFFFFFF, 2);
    do_op("remu_by0", 3'd7, 32'h00001234, 32'd0, 32'h00001234, 2);
    do_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2);
    do_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    do_op("mulh_m2_3", 3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 34);
    do_op("mulhsu_m1", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 34);
    do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 34);
    do_op("div_7_m2", 3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    do_op("rem_7_m2", 3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, 34);

    // Flush in the tenth CALC cycle, then restart immediately
    start_i = 1'b1;
    op_i    = 3'd1;
    a_i     = 32'h12345678;
    b_i     = 32'h9ABCDEF0;
    n       = cyc;
    @(posedge clk); #2;
    start_i = 1'b0;
    repeat (9) begin
      @(posedge clk); #2;
    end
    chk("flush_at_calc10", 64'(cyc - n), 64'd10);
    flush_i = 1'b1;
    @(posedge clk); #2;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy_o), 64'd0);
    chk("flush_done", 64'(done_o), 64'd0);
    @(posedge clk); #2;
    do_op("mulh_restart", 3'd1, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000000, 34);

    // Hold in DONE for five cycles, release, expect IDLE one cycle later
    hold_i = 1'b1;
    do_op("mul_hold", 3'd0, 32'd3, 32'd5, 32'd15, 34);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_done", 64'(done_o), 64'd1);
      chk("hold_result", 64'(result_o), 64'd15);
      chk("hold_stall", 64'(stallreq_o), 64'd0);
    end
    @(posedge clk); #2;
    hold_i = 1'b0;
    @(negedge clk);
    chk("release_done", 64'(done_o), 64'd1);
    @(negedge clk);
    chk("release_idle", 64'(done_o), 64'd0);
    @(posedge clk); #2;

    // Reset in the middle of CALC must abort silently
    start_i = 1'b1;
    op_i    = 3'd4;
    a_i     = 32'd1000;
    b_i     = 32'd3;
    @(posedge clk); #2;
    start_i = 1'b0;
    repeat (5) begin
      @(posedge clk); #2;
    end
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    @(posedge clk); #2;

    // Random traffic: every opcode, corner operands, hold, flush and reset sprinkled in
    for (int i = 0; i < 45000; i++) begin
      int r;
      r       = $urandom_range(0, 999);
      rst_n   = (r >= 2);
      flush_i = (r >= 2 && r < 5);
      hold_i  = ($urandom_range(0, 3) == 0);
      start_i = ($urandom_range(0, 7) != 0);
      op_i    = 3'($urandom_range(0, 7));
      a_i     = pick();
      b_i     = pick();
      @(posedge clk); #2;
    end
    rst_n   = 1'b1;
    flush_i = 1'b0;
    hold_i  = 1'b0;
    start_i = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
